// File: rtl/fpadd_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one pipelined fpadd among N_REQ requesters.
// Optional define FPADD_ARB_NEG_ZERO_FIX_EN canonicalizes -0 operands to +0 before issue.
module fpadd_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 32,
    parameter int LAT   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_op,
    output logic [N_REQ-1:0]   gnt,
    output logic [W-1:0]       adder_a,
    output logic [W-1:0]       adder_b,
    output logic               adder_op,
    input  logic [W-1:0]       adder_result,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       result,
    output logic [3:0]         inflight,
    output logic               busy
);

    localparam int PTR_W = $clog2(N_REQ);

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] id;
    } tag_t;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] ptr_next;
    logic             gnt_vld;
    logic             complete;
    logic [W-1:0]     sel_a;
    logic [W-1:0]     sel_b;
    tag_t             tag_q [LAT+1];

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return PTR_W'(s);
    endfunction

`ifdef FPADD_ARB_NEG_ZERO_FIX_EN
    function automatic logic [W-1:0] canon_zero(input logic [W-1:0] x);
        return (x[W-2:0] == '0) ? '0 : x;
    endfunction
`endif

    // Search starts at ptr and wraps; flush and reset both suppress any grant.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        gnt_vld = 1'b0;
        gnt_idx = ptr_q;
        cand    = ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            cand = wrap_idx(ptr_q, i);
            if (!gnt_vld && req[cand] && rst_n && !flush) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt      = gnt_vld ? (N_REQ'(1) << gnt_idx) : '0;
        ptr_next = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
`ifdef FPADD_ARB_NEG_ZERO_FIX_EN
        sel_a = canon_zero(req_a[gnt_idx*W +: W]);
        sel_b = canon_zero(req_b[gnt_idx*W +: W]);
`else
        sel_a = req_a[gnt_idx*W +: W];
        sel_b = req_b[gnt_idx*W +: W];
`endif
    end

    assign complete = tag_q[LAT].valid;
    assign done     = (complete && !flush) ? (N_REQ'(1) << tag_q[LAT].id) : '0;
    assign result   = (|done) ? adder_result : '0;
    assign busy     = (inflight != 4'd0) | (|(req & {N_REQ{rst_n}}));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= '0;
            adder_a  <= '0;
            adder_b  <= '0;
            adder_op <= 1'b0;
            inflight <= 4'd0;
            // NOTE: the tag array is reset because stale valid bits would emit spurious done pulses.
            for (int s = 0; s <= LAT; s++) tag_q[s] <= '0;
        end else begin
            // NOTE: sequential state uses <= so every stage samples pre-edge values.
            if (gnt_vld) begin
                ptr_q    <= ptr_next;
                adder_a  <= sel_a;
                adder_b  <= sel_b;
                adder_op <= req_op[gnt_idx];
            end
            tag_q[0] <= '{valid: gnt_vld, id: gnt_idx};
            for (int s = 1; s <= LAT; s++) tag_q[s] <= tag_q[s-1];
            if (flush) begin
                for (int s = 0; s <= LAT; s++) tag_q[s].valid <= 1'b0;
                inflight <= 4'd0;
            end else if (gnt_vld && !complete) begin
                inflight <= inflight + 4'd1;
            end else if (!gnt_vld && complete) begin
                inflight <= inflight - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_fpadd_share_arbiter.sv
// Self-checking bench for fpadd_share_arbiter (N_REQ=4, W=32, LAT=2) with a behavioural fpadd stand-in.
module tb_fpadd_share_arbiter;

    localparam int N_REQ = 4;
    localparam int W     = 32;
    localparam int LAT   = 2;

    localparam logic [31:0] A0 = 32'h0000_0100, B0 = 32'h0000_0010, R0 = 32'h0000_0110;
    localparam logic [31:0] A1 = 32'h0000_0200, B1 = 32'h0000_0020, R1 = 32'h0000_0220;
    localparam logic [31:0] A2 = 32'h3F80_0000, B2 = 32'h4000_0000, R2 = 32'h4040_0000;
    localparam logic [31:0] A3 = 32'h0000_0400, B3 = 32'h0000_0040, R3 = 32'h0000_0440;

    logic               clk;
    logic               rst_n;
    logic               flush;
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [N_REQ-1:0]   req_op;
    logic [N_REQ-1:0]   gnt;
    logic [W-1:0]       adder_a;
    logic [W-1:0]       adder_b;
    logic               adder_op;
    logic [W-1:0]       adder_result;
    logic [N_REQ-1:0]   done;
    logic [W-1:0]       result;
    logic [3:0]         inflight;
    logic               busy;

    fpadd_share_arbiter #(.N_REQ(N_REQ), .W(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req(req), .req_a(req_a), .req_b(req_b),
        .req_op(req_op), .gnt(gnt), .adder_a(adder_a), .adder_b(adder_b), .adder_op(adder_op),
        .adder_result(adder_result), .done(done), .result(result), .inflight(inflight), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in adder: exact for the float cases used, integer sum/difference as a unique tag otherwise.
    function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && !op) return 32'h4040_0000;
        if (a == 32'h8000_0000 && b == 32'h0000_0000 && op)  return 32'h8000_0000;
        if (a == 32'h0000_0000 && b == 32'h0000_0000)         return 32'h0000_0000;
        return op ? a - b : a + b;
    endfunction

    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fp_model(adder_a, adder_b, adder_op);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign adder_result = pipe[LAT-1];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic [31:0] res;
        logic [31:0] a;
        logic [3:0]  infl;
        logic        busy;
    } vec_t;

    vec_t vecs [22];

    // Drive inputs just after a rising edge, sample at the falling edge, return just after the next rising edge.
    task automatic cyc(input logic [3:0] r, input logic f);
        req   = r;
        flush = f;
        @(negedge clk);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_a;

    initial begin
        // Round robin from reset, single request, then 4'b1001 wrap sequence.
        vecs[0]  = '{4'b1111, 4'b0001, 4'b0000, 32'h0, 32'h0, 4'd0, 1'b1};
        vecs[1]  = '{4'b1111, 4'b0010, 4'b0000, 32'h0, A0,    4'd1, 1'b1};
        vecs[2]  = '{4'b1111, 4'b0100, 4'b0000, 32'h0, A1,    4'd2, 1'b1};
        vecs[3]  = '{4'b1111, 4'b1000, 4'b0001, R0,    A2,    4'd3, 1'b1};
        vecs[4]  = '{4'b1111, 4'b0001, 4'b0010, R1,    A3,    4'd3, 1'b1};
        vecs[5]  = '{4'b1111, 4'b0010, 4'b0100, R2,    A0,    4'd3, 1'b1};
        vecs[6]  = '{4'b0000, 4'b0000, 4'b1000, R3,    A1,    4'd3, 1'b1};
        vecs[7]  = '{4'b0000, 4'b0000, 4'b0001, R0,    A1,    4'd2, 1'b1};
        vecs[8]  = '{4'b0000, 4'b0000, 4'b0010, R1,    A1,    4'd1, 1'b1};
        vecs[9]  = '{4'b0000, 4'b0000, 4'b0000, 32'h0, A1,    4'd0, 1'b0};
        vecs[10] = '{4'b0100, 4'b0100, 4'b0000, 32'h0, A1,    4'd0, 1'b1};
        vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 32'h0, A2,    4'd1, 1'b1};
        vecs[12] = '{4'b0000, 4'b0000, 4'b0000, 32'h0, A2,    4'd1, 1'b1};
        vecs[13] = '{4'b0000, 4'b0000, 4'b0100, R2,    A2,    4'd1, 1'b1};
        vecs[14] = '{4'b0001, 4'b0001, 4'b0000, 32'h0, A2,    4'd0, 1'b1};
        vecs[15] = '{4'b1001, 4'b1000, 4'b0000, 32'h0, A0,    4'd1, 1'b1};
        vecs[16] = '{4'b1001, 4'b0001, 4'b0000, 32'h0, A3,    4'd2, 1'b1};
        vecs[17] = '{4'b1000, 4'b1000, 4'b0001, R0,    A0,    4'd3, 1'b1};
        vecs[18] = '{4'b0000, 4'b0000, 4'b1000, R3,    A3,    4'd3, 1'b1};
        vecs[19] = '{4'b0000, 4'b0000, 4'b0001, R0,    A3,    4'd2, 1'b1};
        vecs[20] = '{4'b0000, 4'b0000, 4'b1000, R3,    A3,    4'd1, 1'b1};
        vecs[21] = '{4'b0000, 4'b0000, 4'b0000, 32'h0, A3,    4'd0, 1'b0};

        rst_n  = 1'b0;
        flush  = 1'b0;
        req    = 4'b1111;
        req_a  = {A3, A2, A1, A0};
        req_b  = {B3, B2, B1, B0};
        req_op = 4'b0000;
        repeat (2) @(posedge clk);
        #1;

        // Requests present while reset is held must be ignored.
        check("reset gnt", 32'(gnt), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset inflight", 32'(inflight), 32'h0);
        check("reset done", 32'(done), 32'h0);
        check("reset adder_a", adder_a, 32'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 22; i++) begin
            cyc(vecs[i].req, 1'b0);
            check($sformatf("row%0d gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("row%0d done", i), 32'(done), 32'(vecs[i].done));
            check($sformatf("row%0d result", i), result, vecs[i].res);
            check($sformatf("row%0d adder_a", i), adder_a, vecs[i].a);
            check($sformatf("row%0d inflight", i), 32'(inflight), 32'(vecs[i].infl));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].busy));
            if (i == 11) check("single adder_b", adder_b, B2);
            next_cycle();
        end

        // Flush with two ops in flight and requester 2 waiting (ptr is 0 here).
        cyc(4'b0001, 1'b0); check("flush pre gnt0", 32'(gnt), 32'h1); next_cycle();
        cyc(4'b0010, 1'b0); check("flush pre gnt1", 32'(gnt), 32'h2); next_cycle();
        cyc(4'b0100, 1'b1);
        check("flush gnt suppressed", 32'(gnt), 32'h0);
        check("flush inflight before", 32'(inflight), 32'h2);
        next_cycle();
        cyc(4'b0100, 1'b0);
        check("after flush gnt2", 32'(gnt), 32'h4);
        check("after flush inflight", 32'(inflight), 32'h0);
        check("after flush done", 32'(done), 32'h0);
        next_cycle();
        cyc(4'b0000, 1'b0); check("flushed op1 no done", 32'(done), 32'h0); next_cycle();
        cyc(4'b0000, 1'b0); check("idle done", 32'(done), 32'h0); next_cycle();
        cyc(4'b0000, 1'b0);
        check("post flush done", 32'(done), 32'h4);
        check("post flush result", result, R2);
        next_cycle();

        // Flush landing exactly on the completing cycle drops that result.
        cyc(4'b0001, 1'b0); check("flush2 gnt0", 32'(gnt), 32'h1); next_cycle();
        cyc(4'b0000, 1'b0); next_cycle();
        cyc(4'b0000, 1'b0); next_cycle();
        cyc(4'b0000, 1'b1);
        check("flush on completion done", 32'(done), 32'h0);
        check("flush on completion result", result, 32'h0);
        next_cycle();
        cyc(4'b0000, 1'b0);
        check("flush2 inflight", 32'(inflight), 32'h0);
        check("flush2 done", 32'(done), 32'h0);
        next_cycle();

        // Reset mid-operation: three grants (ptr=1 so 1,2,3) then asynchronous reset.
        cyc(4'b1111, 1'b0); check("rst seq gnt1", 32'(gnt), 32'h2); next_cycle();
        cyc(4'b1111, 1'b0); check("rst seq gnt2", 32'(gnt), 32'h4); next_cycle();
        cyc(4'b1111, 1'b0); check("rst seq gnt3", 32'(gnt), 32'h8); next_cycle();
        check("rst seq inflight", 32'(inflight), 32'h3);
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst gnt", 32'(gnt), 32'h0);
        check("async rst done", 32'(done), 32'h0);
        check("async rst result", result, 32'h0);
        check("async rst busy", 32'(busy), 32'h0);
        check("async rst inflight", 32'(inflight), 32'h0);
        check("async rst adder_a", adder_a, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc(4'b0000, 1'b0);
            check($sformatf("post-reset done c%0d", i), 32'(done), 32'h0);
            next_cycle();
        end
        cyc(4'b0110, 1'b0);
        check("first gnt after reset", 32'(gnt), 32'h2);
        next_cycle();
        cyc(4'b0000, 1'b0); next_cycle();
        cyc(4'b0000, 1'b0); next_cycle();

        // Negative zero: -0 - (+0) issued on requester 1.
`ifdef FPADD_ARB_NEG_ZERO_FIX_EN
        exp_a = 32'h0000_0000;
`else
        exp_a = 32'h8000_0000;
`endif
        req_a[1*W +: W] = 32'h8000_0000;
        req_b[1*W +: W] = 32'h0000_0000;
        req_op[1]       = 1'b1;
        cyc(4'b0010, 1'b0); check("negzero gnt", 32'(gnt), 32'h2); next_cycle();
        cyc(4'b0000, 1'b0);
        check("negzero adder_a", adder_a, exp_a);
        check("negzero adder_op", 32'(adder_op), 32'h1);
        next_cycle();
        cyc(4'b0000, 1'b0); next_cycle();
        cyc(4'b0000, 1'b0);
        check("negzero done", 32'(done), 32'h2);
        check("negzero result", result, fp_model(exp_a, 32'h0, 1'b1));
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
